// File: rtl/sfa_pkg.sv
// Shared definitions for the SFA buffer-interface engines.
package sfa_pkg;

   localparam int SFA_PARAM_W = 24;

   localparam logic SFA_MODE_RD = 1'b0;
   localparam logic SFA_MODE_WR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RD_DRAIN,
      ST_WR,
      ST_DONE
   } sfa_state_e;

endpackage

// File: rtl/sfa_skid_fifo.sv
// Two-entry skid FIFO between the BRAM read port and the outgoing stream.
// The caller never pushes when full and never pops when empty.
module sfa_skid_fifo #(
   parameter int W = 33
) (
   input  logic         ACLK,
   input  logic         ARESETN,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;

   // Next pointers, occupancy and storage contents.
   always_comb begin
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
      end
   end

   // Control state: reset empties the FIFO.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge ACLK) begin
      mem_q <= mem_d;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/sfa_bif_stream.sv
// Buffer-interface engine: one strided BRAM<->stream block transfer per ap_start.
module sfa_bif_stream
   import sfa_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 24
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic                   ap_start,
   output logic                   ap_done,
   output logic                   ap_idle,
   output logic                   ap_ready,
   input  logic                   MODE,
   input  logic [SFA_PARAM_W-1:0] INDEX,
   input  logic [SFA_PARAM_W-1:0] SIZE,
   input  logic [SFA_PARAM_W-1:0] STRIDE,
   output logic                   bram_en,
   output logic                   bram_we,
   output logic [ADDR_W-1:0]      bram_addr,
   output logic [DATA_W-1:0]      bram_wdata,
   input  logic [DATA_W-1:0]      bram_rdata,
   output logic                   mOUT_tvalid,
   input  logic                   mOUT_tready,
   output logic [DATA_W-1:0]      mOUT_tdata,
   output logic                   mOUT_tlast,
   input  logic                   sIN_tvalid,
   output logic                   sIN_tready,
   input  logic [DATA_W-1:0]      sIN_tdata
);

   localparam logic [SFA_PARAM_W-1:0] PARAM_ONE = SFA_PARAM_W'(1);

   sfa_state_e             state_q, state_d;
   logic [SFA_PARAM_W-1:0] addr_q, addr_d;
   logic [SFA_PARAM_W-1:0] stride_q, stride_d;
   logic [SFA_PARAM_W-1:0] size_q, size_d;
   logic [SFA_PARAM_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [SFA_PARAM_W-1:0] beat_cnt_q, beat_cnt_d;
   logic                   inflight_q, inflight_d;
   logic                   inflight_last_q, inflight_last_d;

   logic [DATA_W:0]        fifo_head;
   logic [1:0]             fifo_count;
   logic                   pop;
   logic                   rd_issue;
   logic                   wr_hs;
   logic                   issue_last;
   logic                   beat_last;
   logic [2:0]             occ_after;

   // Returned read data (with its tlast tag) lands in the skid FIFO the cycle after issue.
   sfa_skid_fifo #(
      .W (DATA_W + 1)
   ) u_fifo (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .push      (inflight_q),
      .push_data ({inflight_last_q, bram_rdata}),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   // Handshakes, read-issue throttle and next-state logic.
   always_comb begin
      pop        = (fifo_count != 2'd0) && mOUT_tready;
      wr_hs      = (state_q == ST_WR) && sIN_tvalid;
      issue_last = (issue_cnt_q == size_q - PARAM_ONE);
      beat_last  = (beat_cnt_q == size_q - PARAM_ONE);
      // Occupancy after this cycle's pop plus the read already in flight; issue only if room remains.
      occ_after  = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
      rd_issue   = (state_q == ST_RD) && (occ_after < 3'd2);

      state_d         = state_q;
      addr_d          = addr_q;
      stride_d        = stride_q;
      size_d          = size_q;
      issue_cnt_d     = issue_cnt_q;
      beat_cnt_d      = pop ? beat_cnt_q + PARAM_ONE : beat_cnt_q;
      inflight_d      = rd_issue;
      inflight_last_d = rd_issue && issue_last;

      case (state_q)
         ST_IDLE: begin
            if (ap_start) begin
               addr_d      = INDEX;
               stride_d    = STRIDE;
               size_d      = SIZE;
               issue_cnt_d = '0;
               beat_cnt_d  = '0;
               if (SIZE == '0) begin
                  state_d = ST_DONE;
               end else if (MODE == SFA_MODE_WR) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (rd_issue) begin
               addr_d      = addr_q + stride_q;
               issue_cnt_d = issue_cnt_q + PARAM_ONE;
               if (issue_last) begin
                  state_d = ST_RD_DRAIN;
               end
            end
         end
         ST_RD_DRAIN: begin
            // The last beat popping leaves the FIFO empty with nothing in flight.
            if (pop && beat_last) begin
               state_d = ST_DONE;
            end
         end
         ST_WR: begin
            if (wr_hs) begin
               addr_d     = addr_q + stride_q;
               beat_cnt_d = beat_cnt_q + PARAM_ONE;
               if (beat_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers; reset abandons any transfer and drops in-flight read data.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         issue_cnt_q     <= '0;
         beat_cnt_q      <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         issue_cnt_q     <= issue_cnt_d;
         beat_cnt_q      <= beat_cnt_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   // Transfer parameters latched at start; only meaningful while busy.
   always_ff @(posedge ACLK) begin
      stride_q <= stride_d;
      size_q   <= size_d;
   end

   assign ap_idle     = (state_q == ST_IDLE);
   assign ap_done     = (state_q == ST_DONE);
   assign ap_ready    = ap_start && (state_q == ST_IDLE);
   assign bram_en     = rd_issue || wr_hs;
   assign bram_we     = wr_hs;
   assign bram_addr   = addr_q[ADDR_W-1:0];
   assign bram_wdata  = sIN_tdata;
   assign sIN_tready  = (state_q == ST_WR);
   assign mOUT_tvalid = (fifo_count != 2'd0);
   assign mOUT_tdata  = fifo_head[DATA_W-1:0];
   assign mOUT_tlast  = mOUT_tvalid && fifo_head[DATA_W];

endmodule

// File: tb/tb_sfa_bif_stream.sv
// Self-checking bench for sfa_bif_stream against a transfer-level reference.
module tb_sfa_bif_stream;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 24;

   logic              ACLK = 1'b0;
   logic              ARESETN = 1'b0;
   logic              ap_start = 1'b0;
   logic              ap_done, ap_idle, ap_ready;
   logic              MODE = 1'b0;
   logic [23:0]       INDEX = '0, SIZE = '0, STRIDE = '0;
   logic              bram_en, bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wdata;
   logic [DATA_W-1:0] bram_rdata = '0;
   logic              mOUT_tvalid, mOUT_tlast;
   logic              mOUT_tready = 1'b0;
   logic [DATA_W-1:0] mOUT_tdata;
   logic              sIN_tvalid = 1'b0;
   logic              sIN_tready;
   logic [DATA_W-1:0] sIN_tdata = '0;

   sfa_bif_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .ap_start(ap_start), .ap_done(ap_done),
      .ap_idle(ap_idle), .ap_ready(ap_ready), .MODE(MODE), .INDEX(INDEX),
      .SIZE(SIZE), .STRIDE(STRIDE), .bram_en(bram_en), .bram_we(bram_we),
      .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
      .mOUT_tvalid(mOUT_tvalid), .mOUT_tready(mOUT_tready), .mOUT_tdata(mOUT_tdata),
      .mOUT_tlast(mOUT_tlast), .sIN_tvalid(sIN_tvalid), .sIN_tready(sIN_tready),
      .sIN_tdata(sIN_tdata)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // BRAM contents: word k holds k, optionally scrambled by a per-test salt.
   logic [31:0] rd_salt = '0;
   function automatic logic [DATA_W-1:0] rom(input logic [23:0] a);
      return {8'h00, a} ^ rd_salt;
   endfunction

   always @(posedge ACLK) begin
      if (bram_en && !bram_we) bram_rdata <= rom(bram_addr);
   end

   // Observation logs, filled on the falling edge.
   typedef struct { logic [23:0] addr; logic we; logic [31:0] wdata; int c; } acc_t;
   typedef struct { logic last; logic [31:0] data; int c; } beat_t;
   acc_t  acc_q[$];
   beat_t beat_q[$];
   int    done_cnt = 0, ready_cnt = 0, stall_viol = 0, stall_seen = 0;
   logic        prev_stall = 1'b0;
   logic [32:0] prev_beat = '0;

   always @(negedge ACLK) begin
      if (bram_en) acc_q.push_back('{bram_addr, bram_we, bram_wdata, cyc});
      if (mOUT_tvalid && mOUT_tready) beat_q.push_back('{mOUT_tlast, mOUT_tdata, cyc});
      if (prev_stall && !(mOUT_tvalid && {mOUT_tlast, mOUT_tdata} == prev_beat)) stall_viol++;
      if (mOUT_tvalid && !mOUT_tready) stall_seen++;
      prev_stall = mOUT_tvalid && !mOUT_tready;
      prev_beat  = {mOUT_tlast, mOUT_tdata};
      if (ap_done)  done_cnt++;
      if (ap_ready) ready_cnt++;
   end

   // Stream sink: 0 = always ready, 1 = toggling, 2 = random.
   int tready_mode = 0;
   always @(posedge ACLK) begin
      #1;
      case (tready_mode)
         0:       mOUT_tready = 1'b1;
         1:       mOUT_tready = ~mOUT_tready;
         default: mOUT_tready = ($urandom_range(0, 3) != 0);
      endcase
   end

   logic [31:0] wr_words[$];

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ap_idle"}, ap_idle, 1);
      chk({nm, "_ap_done"}, ap_done, 0);
      chk({nm, "_ap_ready"}, ap_ready, 0);
      chk({nm, "_bram_en"}, bram_en, 0);
      chk({nm, "_bram_we"}, bram_we, 0);
      chk({nm, "_bram_addr"}, bram_addr, 0);
      chk({nm, "_tvalid"}, mOUT_tvalid, 0);
      chk({nm, "_tlast"}, mOUT_tlast, 0);
      chk({nm, "_sin_tready"}, sIN_tready, 0);
   endtask

   // Called just after a rising edge; returns at the falling edge of T+1.
   task automatic start_xfer(input logic m, input logic [23:0] idx, sz, str, output int t);
      MODE = m; INDEX = idx; SIZE = sz; STRIDE = str; ap_start = 1'b1;
      acc_q.delete();
      beat_q.delete();
      @(negedge ACLK);
      chk("start_ap_ready", ap_ready, 1);
      chk("start_ap_idle", ap_idle, 1);
      chk("start_ap_done_low", ap_done, 0);
      t = cyc;
      @(posedge ACLK); #1;
      ap_start = 1'b0;
      @(negedge ACLK);
      chk("busy_ap_idle_low", ap_idle, 0);
   endtask

   // Returns just after the rising edge that follows the ap_done cycle.
   task automatic wait_done(output int td);
      int n = 0;
      while (!ap_done && n < 400) begin
         @(negedge ACLK);
         n++;
      end
      chk("done_within_budget", ap_done, 1);
      td = cyc;
      @(posedge ACLK); #1;
   endtask

   task automatic send_words(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         @(posedge ACLK); #1;
         repeat ($urandom_range(0, 2)) begin
            @(posedge ACLK); #1;
         end
         sIN_tvalid = 1'b1;
         sIN_tdata  = wr_words[i];
         k = 0;
         @(negedge ACLK);
         while (!sIN_tready && k < 50) begin
            @(negedge ACLK);
            k++;
         end
         chk("wr_tready_within_budget", sIN_tready, 1);
         @(posedge ACLK); #1;
         sIN_tvalid = 1'b0;
      end
   endtask

   task automatic check_read(input string nm, input logic [23:0] idx, sz, str,
                             input int t, input int td, input bit tight);
      logic [23:0] a;
      chk({nm, "_beats"}, beat_q.size(), sz);
      chk({nm, "_accesses"}, acc_q.size(), sz);
      for (int k = 0; k < beat_q.size() && k < acc_q.size(); k++) begin
         a = idx + 24'(k) * str;
         chk({nm, "_addr"}, acc_q[k].addr, a);
         chk({nm, "_we"}, acc_q[k].we, 0);
         chk({nm, "_data"}, beat_q[k].data, rom(a));
         chk({nm, "_tlast"}, beat_q[k].last, (k == int'(sz) - 1));
      end
      if (beat_q.size() > 0) chk({nm, "_done_after_last"}, td, beat_q[beat_q.size()-1].c + 1);
      chk({nm, "_stall_stable"}, stall_viol, 0);
      if (tight && beat_q.size() > 0 && acc_q.size() > 0) begin
         chk({nm, "_first_access"}, acc_q[0].c, t + 1);
         chk({nm, "_first_beat"}, beat_q[0].c, t + 3);
         chk({nm, "_last_beat"}, beat_q[beat_q.size()-1].c, t + 2 + int'(sz));
      end
   endtask

   task automatic check_write(input string nm, input logic [23:0] idx, sz, str, input int td);
      logic [23:0] a;
      chk({nm, "_accesses"}, acc_q.size(), sz);
      chk({nm, "_no_beats"}, beat_q.size(), 0);
      for (int k = 0; k < acc_q.size() && k < int'(sz); k++) begin
         a = idx + 24'(k) * str;
         chk({nm, "_we"}, acc_q[k].we, 1);
         chk({nm, "_addr"}, acc_q[k].addr, a);
         chk({nm, "_wdata"}, acc_q[k].wdata, wr_words[k]);
      end
      if (acc_q.size() > 0) chk({nm, "_done_after_last"}, td, acc_q[acc_q.size()-1].c + 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, td, d0, r0;
      logic        m;
      logic [23:0] idx, sz, str;

      // Reset state.
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk_reset_outputs("reset");
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;

      // Unit-stride read, sink always ready.
      tready_mode = 0; rd_salt = '0; d0 = done_cnt;
      start_xfer(1'b0, 24'h10, 24'd4, 24'd1, t);
      wait_done(td);
      check_read("rd_unit", 24'h10, 24'd4, 24'd1, t, td, 1'b1);
      chk("rd_unit_data0", beat_q.size() > 0 ? beat_q[0].data : 32'hDEAD, 32'h10);
      chk("rd_unit_done_pulses", done_cnt - d0, 1);

      // Strided read under toggling backpressure.
      tready_mode = 1; stall_seen = 0;
      start_xfer(1'b0, 24'd2, 24'd3, 24'd5, t);
      wait_done(td);
      check_read("rd_stride", 24'd2, 24'd3, 24'd5, t, td, 1'b0);
      chk("rd_stride_saw_stall", stall_seen > 0, 1);

      // Write with tvalid gaps.
      wr_words.delete();
      wr_words.push_back(32'hA); wr_words.push_back(32'hB); wr_words.push_back(32'hC);
      d0 = done_cnt;
      start_xfer(1'b1, 24'h100, 24'd3, 24'd2, t);
      send_words(3);
      wait_done(td);
      check_write("wr_basic", 24'h100, 24'd3, 24'd2, td);
      chk("wr_basic_done_pulses", done_cnt - d0, 1);

      // Address wrap.
      tready_mode = 0;
      start_xfer(1'b0, 24'hFFFFFE, 24'd3, 24'd1, t);
      wait_done(td);
      check_read("rd_wrap", 24'hFFFFFE, 24'd3, 24'd1, t, td, 1'b1);

      // SIZE = 0.
      start_xfer(1'b0, 24'h55, 24'd0, 24'd1, t);
      wait_done(td);
      chk("size0_done_time", td, t + 1);
      chk("size0_no_access", acc_q.size(), 0);
      chk("size0_no_beats", beat_q.size(), 0);

      // ap_start while a read is busy is ignored.
      tready_mode = 1; r0 = ready_cnt;
      start_xfer(1'b0, 24'h40, 24'd8, 24'd3, t);
      repeat (3) begin @(posedge ACLK); #1; end
      MODE = 1'b1; INDEX = 24'h0; SIZE = 24'd1; STRIDE = 24'd1; ap_start = 1'b1;
      @(negedge ACLK);
      chk("busy_start_no_ready", ap_ready, 0);
      @(posedge ACLK); #1;
      ap_start = 1'b0;
      wait_done(td);
      check_read("rd_busy", 24'h40, 24'd8, 24'd3, t, td, 1'b0);
      chk("busy_ready_count", ready_cnt - r0, 1);

      // Reset after 2 of 4 write words.
      wr_words.delete();
      for (int i = 0; i < 4; i++) wr_words.push_back($urandom());
      d0 = done_cnt;
      start_xfer(1'b1, 24'h200, 24'd4, 24'd1, t);
      send_words(2);
      chk("rst_wr_two_writes", acc_q.size(), 2);
      ARESETN = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      chk_reset_outputs("midrst");
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      chk("midrst_no_done", done_cnt - d0, 0);

      // A normal transfer after the abandoned one.
      wr_words.delete();
      for (int i = 0; i < 4; i++) wr_words.push_back($urandom());
      start_xfer(1'b1, 24'h300, 24'd4, 24'd7, t);
      send_words(4);
      wait_done(td);
      check_write("wr_after_rst", 24'h300, 24'd4, 24'd7, td);

      // Randomized transfers, back to back.
      tready_mode = 2;
      for (int r = 0; r < 10; r++) begin
         m   = 1'($urandom_range(0, 1));
         idx = 24'($urandom());
         sz  = 24'($urandom_range(1, 9));
         str = ($urandom_range(0, 1) != 0) ? 24'($urandom()) : 24'($urandom_range(0, 4));
         rd_salt = $urandom();
         stall_viol = 0;
         if (m) begin
            wr_words.delete();
            for (int i = 0; i < int'(sz); i++) wr_words.push_back($urandom());
            start_xfer(1'b1, idx, sz, str, t);
            send_words(int'(sz));
            wait_done(td);
            check_write("rnd_wr", idx, sz, str, td);
         end else begin
            start_xfer(1'b0, idx, sz, str, t);
            wait_done(td);
            check_read("rnd_rd", idx, sz, str, t, td, 1'b0);
         end
      end

      @(negedge ACLK);
      chk("final_idle", ap_idle, 1);
      chk("final_done_low", ap_done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfa_bif_stream.md
# sfa_bif_stream

Buffer-interface engine that executes one strided block transfer per `ap_start` pulse from the SFA controller's BC1/BC2 ports. It bridges one local BRAM port and the SFA switch fabric.
- MODE 0 (read): fetches SIZE words from BRAM at INDEX, INDEX+STRIDE, … and streams them out.
- MODE 1 (write): accepts SIZE words from the fabric and stores them at the same address sequence.

Two instances sit directly downstream of the controller, one per BIF.

## Interface
Parameters:
- DATA_W, 32, stream and BRAM data width
- ADDR_W, 24, BRAM word-address width (≤ 24)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous, active-low reset
- ap_start  in  1  one-cycle request; parameters are sampled in the same cycle
- ap_done  out  1  one-cycle pulse at transfer completion
- ap_idle  out  1  high while in IDLE
- ap_ready  out  1  one-cycle pulse when a start is accepted
- MODE  in  1  0 = BRAM→stream, 1 = stream→BRAM
- INDEX  in  24  start word address
- SIZE  in  24  word count
- STRIDE  in  24  address increment per word
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_W  BRAM word address
- bram_wdata  out  DATA_W  write data
- bram_rdata  in  DATA_W  read data, valid one cycle after `bram_en` with `!bram_we`
- mOUT_tvalid / mOUT_tready / mOUT_tdata / mOUT_tlast  out/in/out/out  1/1/DATA_W/1  read-mode stream
- sIN_tvalid / sIN_tready / sIN_tdata  in/out/in  1/1/DATA_W  write-mode stream

## Operation
- States are IDLE, RD, RD_DRAIN, WR and DONE.
- **Start:** `ap_start` in IDLE latches MODE, INDEX, SIZE and STRIDE, and pulses `ap_ready` in the same cycle (combinational on `ap_start & idle`). Next state is RD or WR. `ap_start` outside IDLE is ignored.
- **SIZE = 0:** next state is DONE directly; no BRAM access and no stream beat occurs.
- **Addressing:** address counter `addr` starts at INDEX and adds STRIDE after each issued access. It is 24-bit modulo-2^24 and `bram_addr` carries its low ADDR_W bits, so wrap is silent. Issue counter and beat counter are both 24 bits.
- **RD:**
  - Issue a read (`bram_en`=1, `bram_we`=0) whenever the 2-entry output skid FIFO can absorb it, counting the one in-flight read.
  - Returned data enters the FIFO; the FIFO head drives `mOUT`.
  - After SIZE reads are issued, go to RD_DRAIN.
  - `mOUT_tlast` = 1 on beat SIZE only.
- **RD_DRAIN:** wait until the FIFO is empty and the last beat has completed its handshake, then go to DONE.
- **WR:**
  - `sIN_tready` = 1. Each handshake drives `bram_en` = `bram_we` = 1, `bram_addr` = `addr` and `bram_wdata` = `sIN_tdata` in the same cycle (combinational).
  - After handshake SIZE, go to DONE.
- **DONE:** `ap_done` = 1 for exactly one cycle, then IDLE.
- **Reset values:** state IDLE, `ap_idle` 1, `ap_done`/`ap_ready` 0, `bram_en`/`bram_we` 0, `bram_addr` 0, `mOUT_tvalid` 0, `mOUT_tlast` 0, `sIN_tready` 0. FIFO is emptied and counters cleared.
- **Reset mid-transfer:** abandons the transfer. There is no `ap_done`, and in-flight read data is discarded.
- **Backpressure:** `mOUT_tvalid` must not drop and `mOUT_tdata` must not change while `mOUT_tready` = 0. The FIFO never overflows, because reads stop issuing when FIFO occupancy plus in-flight reads reaches 2.

## Timing
- Start to first BRAM access: 1 cycle (`ap_start` at T, first access at T+1).
- Read latency: first `mOUT_tvalid` at T+3 (issue T+1, data T+2, registered into FIFO T+3).
- Throughput: one beat per cycle in both modes while the stream partner stays ready/valid.
- `ap_done`:
  - Read mode: the cycle after the last `mOUT` handshake.
  - Write mode: the cycle after the last write.
  - SIZE = 0: T+1.
- `ap_idle` is low from T+1 until the cycle after `ap_done`.
- A new `ap_start` is accepted the cycle after `ap_done`, giving back-to-back transfers with one idle cycle.

## Structure
- Shared package `sfa_pkg` holds:
  - MODE encodings `SFA_MODE_RD` = 0 and `SFA_MODE_WR` = 1
  - the state enum
  - `SFA_PARAM_W` = 24
- Sub-module `sfa_skid_fifo`: 2-entry, DATA_W+1 wide (data plus tlast), with `push`/`pop`/`count` ports. Instantiated once on the read path.

## Test plan
- **Read, unit stride:** MODE 0, INDEX 0x10, SIZE 4, STRIDE 1, BRAM[k] = k, `mOUT_tready` = 1 → tdata 0x10, 0x11, 0x12, 0x13 on consecutive cycles starting T+3; tlast on 0x13 only; `ap_done` one cycle after.
- **Strided read with backpressure:** MODE 0, INDEX 2, SIZE 3, STRIDE 5, tready toggling 1/0 → addresses 2, 7, 12; data order preserved; tdata held stable during every stall; exactly 3 beats.
- **Write:** MODE 1, INDEX 0x100, SIZE 3, STRIDE 2, `sIN` words 0xA, 0xB, 0xC with tvalid gaps → BRAM[0x100] = 0xA, BRAM[0x102] = 0xB, BRAM[0x104] = 0xC; one `ap_done` pulse.
- **Wrap and SIZE = 0:**
  - INDEX 0xFFFFFE, STRIDE 1, SIZE 3, ADDR_W 24 → addresses 0xFFFFFE, 0xFFFFFF, 0x000000.
  - SIZE 0 → `ap_ready` at T, `ap_done` at T+1, no `bram_en`, no beats.
- **Protocol abuse and reset:**
  - `ap_start` pulsed during a busy read → ignored, no `ap_ready`.
  - ARESETN low mid-write (after 2 of 4 words) → all outputs at reset values next cycle, no `ap_done`.
  - A subsequent transfer then completes normally.
